// File: rtl/alu_arbiter_ctrl.sv
// Round-robin controller sharing one structural 32-bit ALU between requesters A and B.
// Define ALU_CTRL_MUL_EN to enable the shift-add multiply (op 011); otherwise 011 is illegal.
module alu_arbiter_ctrl #(
   parameter int unsigned MUL_ITERS    = 32,
   parameter int unsigned RR_RESET_PRI = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [2:0]  a_op,
   input  logic [31:0] a_opa,
   input  logic [31:0] a_opb,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [2:0]  b_op,
   input  logic [31:0] b_opa,
   input  logic [31:0] b_opb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_cout,
   output logic        rsp_set,
   output logic        rsp_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_s1,
   output logic        alu_s2,
   output logic        alu_sub,
   output logic        alu_cin,
   input  logic [31:0] alu_f,
   input  logic        alu_cout,
   input  logic        alu_zero,
   input  logic        alu_set
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [OP_W-1:0] OP_AND = 3'b000;
   localparam logic [OP_W-1:0] OP_OR  = 3'b010;
   localparam logic [OP_W-1:0] OP_ADD = 3'b100;
   localparam logic [OP_W-1:0] OP_SUB = 3'b101;
   localparam logic [OP_W-1:0] OP_SLT = 3'b111;

   if (MUL_ITERS < 1 || MUL_ITERS > 32) begin : g_bad_iters
      $error("alu_arbiter_ctrl: MUL_ITERS must be in 1..32");
   end

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic              ptr;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] opa_q;
   logic [DATA_W-1:0] opb_q;
   logic              id_q;

   logic              idle_ok;
   logic              grant_a;
   logic              grant_b;
   logic              accept;
   logic [OP_W-1:0]   sel_op;
   logic [DATA_W-1:0] sel_opa;
   logic [DATA_W-1:0] sel_opb;
   logic              sel_legal;
   logic              slt_lt;
   logic [DATA_W-1:0] exec_res;

`ifdef ALU_CTRL_MUL_EN
   localparam logic [1:0]      MUL    = 2'd2;
   localparam logic [OP_W-1:0] OP_MUL = 3'b011;
   localparam int unsigned     CNT_W  = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] acc_nx;
   logic              mul_last;

   assign acc_nx   = mplier[0] ? alu_f : acc;
   assign mul_last = (cnt == CNT_W'(MUL_ITERS - 1));
`endif

   // Arbitration: pointer side wins a collision; only offered while idle and out of reset.
   assign idle_ok = (state == IDLE) && !rst;
   assign grant_a = idle_ok && a_valid && (!b_valid || !ptr);
   assign grant_b = idle_ok && b_valid && (!a_valid || ptr);
   assign accept  = grant_a || grant_b;
   assign a_ready = grant_a;
   assign b_ready = grant_b;

   assign sel_op  = grant_b ? b_op  : a_op;
   assign sel_opa = grant_b ? b_opa : a_opa;
   assign sel_opb = grant_b ? b_opb : a_opb;

   always_comb begin
      sel_legal = 1'b0;
      case (sel_op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: sel_legal = 1'b1;
`ifdef ALU_CTRL_MUL_EN
         OP_MUL:                                sel_legal = 1'b1;
`endif
         default:                               sel_legal = 1'b0;
      endcase
   end

   // Signed compare: differing signs decide directly, otherwise the difference sign does.
   assign slt_lt   = (opa_q[DATA_W-1] != opb_q[DATA_W-1]) ? opa_q[DATA_W-1] : alu_f[DATA_W-1];
   assign exec_res = (op_q == OP_SLT) ? {{(DATA_W-1){1'b0}}, slt_lt} : alu_f;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!sel_legal) begin
                  state_nx = RESP;
`ifdef ALU_CTRL_MUL_EN
               end else if (sel_op == OP_MUL) begin
                  state_nx = MUL;
`endif
               end else begin
                  state_nx = EXEC;
               end
            end
         end
         EXEC: state_nx = RESP;
`ifdef ALU_CTRL_MUL_EN
         MUL: begin
            if (mul_last) begin
               state_nx = RESP;
            end
         end
`endif
         RESP: begin
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ALU drive: operands and function select only while the ALU is in use.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_s1  = 1'b0;
      alu_s2  = 1'b0;
      alu_sub = 1'b0;
      alu_cin = 1'b0;
      if (state == EXEC) begin
         alu_a = opa_q;
         alu_b = opb_q;
         case (op_q)
            OP_OR:  alu_s2 = 1'b1;
            OP_ADD: alu_s1 = 1'b1;
            OP_SUB: begin
               alu_s1  = 1'b1;
               alu_sub = 1'b1;
            end
            OP_SLT: begin
               alu_s1  = 1'b1;
               alu_s2  = 1'b1;
               alu_sub = 1'b1;
            end
            default: ;
         endcase
      end
`ifdef ALU_CTRL_MUL_EN
      else if (state == MUL) begin
         alu_a  = acc;
         alu_b  = mcand;
         alu_s1 = 1'b1;
      end
`endif
   end

`ifdef ALU_CTRL_MUL_EN
   // Shift-add multiply: accumulate the shifted multiplicand when the current multiplier bit is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= sel_opa;
         mplier <= sel_opb;
         cnt    <= '0;
      end else if (state == MUL) begin
         acc    <= acc_nx;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= 1'(RR_RESET_PRI);
         op_q       <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         id_q       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_cout   <= 1'b0;
         rsp_set    <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= sel_op;
            opa_q <= sel_opa;
            opb_q <= sel_opb;
            id_q  <= grant_b;
            if (a_valid && b_valid) begin
               ptr <= ~ptr;
            end
            if (!sel_legal) begin
               rsp_valid  <= 1'b1;
               rsp_id     <= grant_b;
               rsp_result <= '0;
               rsp_zero   <= 1'b0;
               rsp_cout   <= 1'b0;
               rsp_set    <= 1'b0;
               rsp_err    <= 1'b1;
            end
         end
         if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= exec_res;
            rsp_zero   <= alu_zero;
            rsp_cout   <= alu_cout;
            rsp_set    <= alu_set;
            rsp_err    <= 1'b0;
         end
`ifdef ALU_CTRL_MUL_EN
         if (state == MUL && mul_last) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= acc_nx;
            rsp_zero   <= (acc_nx == '0);
            rsp_cout   <= 1'b0;
            rsp_set    <= 1'b0;
            rsp_err    <= 1'b0;
         end
`endif
         if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
